// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: default geometry, segment
// patterns ({G,F,E,D,C,B,A}, active high) and the scan FSM state type.
package seg7_pkg;

    localparam int N_DIG_DEF     = 4;
    localparam int SLOT_CYC_DEF  = 1000;
    localparam int BLANK_CYC_DEF = 8;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational BCD to 7-segment decoder; codes 10-15 produce an unlit digit.
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller with frame-synchronous data update.
// Define SEG7_LZB_EN to blank leading zeros (digit 0 is always shown).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIG     = N_DIG_DEF,
    parameter int SLOT_CYC  = SLOT_CYC_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [4*N_DIG-1:0] value,
    input  logic [N_DIG-1:0]   dp_in,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [N_DIG-1:0]   an,
    output logic               frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYC);
    localparam int IDX_W = $clog2(N_DIG);
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DIG - 1);

    scan_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [4*N_DIG-1:0] pend_val;
    logic [4*N_DIG-1:0] disp_val;
    logic [N_DIG-1:0]   pend_dp;
    logic [N_DIG-1:0]   disp_dp;
    logic               pend_vld;
    logic               frame_wrap;
    logic [3:0]         cur_code;
    logic [6:0]         seg_dec;
    logic [6:0]         seg_show;
    logic [N_DIG-1:0]   an_sel;

    assign frame_wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign cur_code   = disp_val[4*idx +: 4];

    seg7_digit_dec u_dec (
        .bcd (cur_code),
        .seg (seg_dec)
    );

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every more significant digit are zero.
    logic lz_run;
    logic lz_blank;

    always_comb begin
        lz_run   = 1'b1;
        lz_blank = 1'b0;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            lz_run = lz_run && (disp_val[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                lz_blank = lz_run;
            end
        end
    end

    assign seg_show = lz_blank ? SEG_BLANK : seg_dec;
`else
    assign seg_show = seg_dec;
`endif

    always_comb begin
        an_sel      = '0;
        an_sel[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_vld   <= 1'b0;
            disp_val   <= '0;
            disp_dp    <= '0;
            seg        <= SEG_BLANK;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            // slot timing and digit index
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                state <= ST_BLANK;
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == CNT_BLK_LAST) begin
                    state <= ST_SHOW;
                end
            end

            // pending data only reaches the display at a frame boundary
            if (frame_wrap) begin
                if (load) begin
                    disp_val <= value;
                    disp_dp  <= dp_in;
                end else if (pend_vld) begin
                    disp_val <= pend_val;
                    disp_dp  <= pend_dp;
                end
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_val <= value;
                pend_dp  <= dp_in;
                pend_vld <= 1'b1;
            end

            // registered outputs, one cycle behind the scan state
            frame_done <= frame_wrap;
            if (state == ST_SHOW) begin
                an  <= an_sel;
                seg <= seg_show;
                dp  <= disp_dp[idx];
            end else begin
                an  <= '0;
                seg <= SEG_BLANK;
                dp  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed + randomized bench for seg7_scan_ctrl against a cycle-position reference model.
module tb_seg7_scan_ctrl;

    localparam int N = 4;
    localparam int S = 16;
    localparam int B = 2;
    localparam int F = S * N;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int tests;
    int fails;

    // reference model state: cycle index since reset and per-frame display data
    int          cyc;
    logic [15:0] m_cur_v;
    logic [15:0] m_nxt_v;
    logic [3:0]  m_cur_d;
    logic [3:0]  m_nxt_d;
    bit          m_nxt_set;

    seg7_scan_ctrl #(
        .N_DIG     (N),
        .SLOT_CYC  (S),
        .BLANK_CYC (B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] pattern(input logic [3:0] code);
        case (code)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Expected {an,seg,dp,frame_done} registered at the edge that ends cycle c.
    function automatic logic [12:0] model_out(input int c, input logic [15:0] v, input logic [3:0] d);
        int         pos;
        int         dig;
        int         msnz;
        logic       fd;
        logic [6:0] s;
        logic [3:0] onehot;
        pos  = c % S;
        dig  = (c / S) % N;
        fd   = ((c % F) == F - 1);
        if (pos < B) return {4'b0000, 7'h00, 1'b0, fd};
        s    = pattern(v[dig*4 +: 4]);
        msnz = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i*4 +: 4] != 4'd0) msnz = i;
        end
`ifdef SEG7_LZB_EN
        if (dig > msnz) s = 7'h00;
`endif
        onehot = 4'(1 << dig);
        return {onehot, s, d[dig], fd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc       = 0;
        m_cur_v   = '0;
        m_cur_d   = '0;
        m_nxt_v   = '0;
        m_nxt_d   = '0;
        m_nxt_set = 0;
    endtask

    // Starts and ends just after a falling edge; checks every output at each rising edge.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d);
        logic [12:0] e;
        load  = ld;
        value = v;
        dp_in = d;
        @(posedge clk);
        e = model_out(cyc, m_cur_v, m_cur_d);
        if (ld) begin
            m_nxt_v   = v;
            m_nxt_d   = d;
            m_nxt_set = 1;
        end
        if ((cyc % F) == F - 1) begin
            if (m_nxt_set) begin
                m_cur_v = m_nxt_v;
                m_cur_d = m_nxt_d;
            end
            m_nxt_set = 0;
        end
        cyc++;
        #1;
        check($sformatf("out@cyc%0d", cyc - 1), 32'({an, seg, dp, frame_done}), 32'(e));
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, value, dp_in);
    endtask

    // Idle until the next cycle to be driven is at the given digit/slot position.
    task automatic advance_to(input int dig, input int pos);
        for (int k = 0; k < F; k++) begin
            if ((cyc % S) == pos && ((cyc / S) % N) == dig) break;
            step(1'b0, value, dp_in);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        dp_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_an", 32'(an), 32'(0));
        check("rst_seg", 32'(seg), 32'(0));
        check("rst_dp_fd", 32'({dp, frame_done}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // first SHOW appears at cycle B+1 showing "0"
        idle(B);
        check("first_blank_an", 32'(an), 32'(0));
        step(1'b0, '0, '0);
        check("first_show_an", 32'(an), 32'(4'b0001));
        check("first_show_seg", 32'(seg), 32'(7'h3F));
        idle(F);

        // load during digit 1 waits for the frame boundary
        advance_to(1, 5);
        step(1'b1, 16'h1234, 4'b0000);
        advance_to(3, 8);
        step(1'b0, 16'h0000, 4'b0000);
        check("midload_old_d3", 32'(seg), 32'(7'h3F));
        advance_to(0, 8);
        step(1'b0, 16'h0000, 4'b0000);
        check("midload_new_d0", 32'(seg), 32'(7'h66));
        advance_to(3, 8);
        step(1'b0, 16'h0000, 4'b0000);
        check("midload_new_d3", 32'(seg), 32'(7'h06));

        // load on the wrap cycle itself goes straight to the display
        advance_to(3, 15);
        step(1'b1, 16'h9999, 4'b0000);
        check("frame_done_pulse", 32'(frame_done), 32'(1));
        step(1'b0, 16'h0000, 4'b0000);
        check("frame_done_single", 32'(frame_done), 32'(0));
        advance_to(0, 4);
        step(1'b0, 16'h0000, 4'b0000);
        check("wrapload_d0", 32'(seg), 32'(7'h6F));
        advance_to(2, 4);
        step(1'b0, 16'h0000, 4'b0000);
        check("wrapload_d2", 32'(seg), 32'(7'h6F));

        // invalid code still enables the digit but lights nothing
        step(1'b1, 16'h00A0, 4'b0000);
        advance_to(0, 0);
        advance_to(1, 6);
        step(1'b0, 16'h0000, 4'b0000);
        check("invalid_seg", 32'(seg), 32'(0));
        check("invalid_an", 32'(an), 32'(4'b0010));

        // leading zeros and decimal point
        step(1'b1, 16'h0050, 4'b1000);
        advance_to(0, 0);
        advance_to(0, 6);
        step(1'b0, 16'h0000, 4'b0000);
        check("lz_d0", 32'(seg), 32'(7'h3F));
        advance_to(1, 6);
        step(1'b0, 16'h0000, 4'b0000);
        check("lz_d1", 32'(seg), 32'(7'h6D));
        advance_to(3, 6);
        step(1'b0, 16'h0000, 4'b0000);
        check("lz_d3_dp", 32'(dp), 32'(1));
`ifdef SEG7_LZB_EN
        check("lz_d3_seg", 32'(seg), 32'(7'h00));
`else
        check("lz_d3_seg", 32'(seg), 32'(7'h3F));
`endif

        // randomized loads, including codes 10-15 and back-to-back loads
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0)
                step(1'b1, 16'($urandom), 4'($urandom));
            else
                step(1'b0, value, dp_in);
        end

        // async reset mid-SHOW with pending data, no clock edge needed
        step(1'b1, 16'h7777, 4'b1111);
        advance_to(2, 8);
        step(1'b0, 16'h0000, 4'b0000);
        check("pre_reset_an", 32'(an), 32'(4'b0100));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'(0));
        check("async_rst_seg", 32'(seg), 32'(0));
        check("async_rst_fd_dp", 32'({frame_done, dp}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        value = '0;
        dp_in = '0;
        idle(F + S);
        advance_to(1, 5);
        step(1'b0, 16'h0000, 4'b0000);
        check("pending_discarded", 32'(seg), 32'(7'h3F));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
